// File: rtl/timing_sequencer_pkg.sv
// Shared types and constants for the timing sequencer
// and the control logic that consumes T/D.
package timing_sequencer_pkg;

  localparam int SC_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int D_AND = 0;
  localparam int D_ADD = 1;
  localparam int D_LDA = 2;
  localparam int D_STA = 3;
  localparam int D_BUN = 4;
  localparam int D_BSA = 5;
  localparam int D_ISZ = 6;
  localparam int D_IO  = 7;

endpackage

// File: rtl/decoder_3to8.sv
// Binary to one-hot decoder with enable;
// output is all zeros when disabled.
module decoder_3to8 #(
  parameter int N = 3
) (
  input  logic [N-1:0]      a,
  input  logic              en,
  output logic [2**N-1:0]   y
);

  always_comb begin
    y = '0;
    if (en) y[a] = 1'b1;
  end

endmodule

// File: rtl/timing_sequencer.sv
// Instruction timing sequencer: sequence counter,
// T/D one-hot timing and IDLE/RUN/HALT control.
module timing_sequencer
  import timing_sequencer_pkg::*;
#(
  parameter int SC_W = timing_sequencer_pkg::SC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clr_sc,
  input  logic               halt_req,
  input  logic [3:0]         ir_op,
  output logic [2**SC_W-1:0] T,
  output logic [7:0]         D,
  output logic               I,
  output logic [SC_W-1:0]    sc,
  output logic               running,
  output logic               instr_done,
  output logic               seq_err
);

  localparam logic [SC_W-1:0] SC_MAX = '1;
  localparam logic [SC_W-1:0] SC_LD  = SC_W'(2);

  state_t          state_q, state_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [7:0]      d_q, d_d, d_dec;
  logic            i_q, i_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sc_q    <= '0;
      d_q     <= '0;
      i_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      d_q     <= d_d;
      i_q     <= i_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Opcode is captured during T2 so D/I are stable from T3.
  assign load = running && (sc_q == SC_LD);

  always_comb begin
    state_d = state_q;
    sc_d    = '0;
    d_d     = load ? d_dec : d_q;
    i_d     = load ? ir_op[3] : i_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        done_d = clr_sc;
        if (clr_sc) begin
          if (halt_req) state_d = HALT;
        end else begin
          sc_d = sc_q + SC_W'(1);
          if (sc_q == SC_MAX) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    running = (state_q == RUN);
  end

  decoder_3to8 #(.N(SC_W)) u_dec_t (
    .a  (sc_q),
    .en (running),
    .y  (T)
  );

  decoder_3to8 #(.N(3)) u_dec_d (
    .a  (ir_op[2:0]),
    .en (load),
    .y  (d_dec)
  );

  assign sc         = sc_q;
  assign D          = d_q;
  assign I          = i_q;
  assign instr_done = done_q;
  assign seq_err    = err_q;

endmodule

// File: doc/timing_sequencer.md
TIMING_SEQUENCER -- requirements
Module: timing_sequencer

Interface
REQ-001 The module SHALL run on one clock, with reset asynchronous and active-low (clk, rst_n).
REQ-002 The module SHALL have one parameter: SC_W, default 3, sequence counter width; T and D widths are 2**SC_W (8).
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  level; starts the sequencer from IDLE, or resumes it from HALT.
REQ-006 clr_sc  input  1  end-of-instruction from control logic; clears the sequence counter.
REQ-007 halt_req  input  1  HLT instruction decoded; sampled only together with clr_sc.
REQ-008 ir_op  input  4  IR[15:12]: bit 3 is the I bit, bits 2:0 are the opcode.
REQ-009 T  output  8  one-hot timing signals T0..T7.
REQ-010 D  output  8  one-hot decoded opcode D0..D7.
REQ-011 I  output  1  latched indirect bit.
REQ-012 sc  output  3  current sequence count.
REQ-013 running  output  1  high while the state is RUN.
REQ-014 instr_done  output  1  one-cycle pulse, registered.
REQ-015 seq_err  output  1  sticky: sequence overrun.

Function
REQ-016 The FSM SHALL have three states, IDLE, RUN and HALT, with the following transitions:
- IDLE->RUN on start.
- RUN->HALT on clr_sc & halt_req.
- HALT->RUN on start.
- No other transitions.
REQ-017 In RUN, sc SHALL increment by 1 each cycle unless clr_sc=1, in which case sc=0 on the next cycle.
REQ-018 In IDLE and HALT, sc SHALL hold at 0.
REQ-019 T SHALL be the combinational one-hot decode of the registered sc, gated by running; T SHALL be 8'h00 outside RUN.
REQ-020 The first RUN cycle after start SHALL present T=8'h01 (T0).
REQ-021 When sc==2 in RUN, D SHALL be loaded with onehot(ir_op[2:0]) and I with ir_op[3]; both are visible from T3 onward.
REQ-022 D and I SHALL otherwise hold their values, including across HALT.
REQ-023 instr_done SHALL pulse high for one cycle in the cycle after clr_sc is sampled in RUN.
REQ-024 halt_req without clr_sc SHALL be ignored; halt takes effect only at the end of an instruction.
REQ-025 clr_sc and halt_req together in RUN SHALL give HALT next cycle, with sc=0 and instr_done=1.
REQ-026 If sc==7 in RUN and clr_sc=0, sc SHALL wrap to 0 and seq_err SHALL set.
REQ-027 seq_err SHALL clear only on reset or on a start accepted from IDLE or HALT.
REQ-028 sc==7 together with clr_sc=1 SHALL be legal: sc=0 with no seq_err.
REQ-029 start while in RUN SHALL be ignored.
REQ-030 clr_sc while in IDLE or HALT SHALL be ignored.
REQ-031 start and clr_sc together in HALT SHALL give resume, with sc=0 next cycle.
REQ-032 running SHALL equal (state==RUN), decoded from the registered state.

Reset
REQ-033 rst_n low SHALL immediately force state=IDLE, sc=0, D=8'h00, I=0, instr_done=0, seq_err=0 and running=0, so that T=8'h00.
REQ-034 Reset asserted during RUN SHALL abort the current instruction; no instr_done pulse is produced.
REQ-035 After rst_n deasserts, the block SHALL remain in IDLE until start.

Structure
REQ-036 A shared package SHALL hold the following, for reuse by the control-signal and RAM-control logic:
- the state enum (IDLE, RUN, HALT);
- SC_W;
- opcode index constants (D_AND=0 ... D_IO=7).
REQ-037 A single sub-module, decoder_3to8 (3-bit in, 8-bit one-hot out, with enable), SHALL be instantiated twice: once for T and once for D-load.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- Basic fetch: reset, then start=1 for one cycle -> T sequence 01,02,04,08 on consecutive cycles; ir_op=4'b1011 at T2 -> D=8'h08, I=1 at T3.
- End of instruction: clr_sc at T5 -> next cycle T=8'h01, instr_done=1 for exactly one cycle.
- Halt: clr_sc=1 and halt_req=1 at T4 -> running=0, T=8'h00, D held; start -> T0 next cycle.
- Overrun: no clr_sc for 8 cycles -> sc wraps 7->0, seq_err=1 and stays set; start from HALT clears it.
- Edge cases: halt_req alone at T3 -> no effect; start during RUN -> no effect; clr_sc at sc==7 -> seq_err stays 0.
- Reset mid-RUN: rst_n low at T4 -> T=8'h00, D=8'h00 immediately; no instr_done pulse.
